// File: rtl/rgb2ycbcr_mac.sv
// One RGB->YCbCr output channel: serial R,G,B beats are multiplied by per-beat
// coefficients, summed with offset and rounding, then clamped to an unsigned byte.
module rgb2ycbcr_mac #(
  parameter logic signed [15:0] C1     = 16'sd2449,
  parameter logic signed [15:0] C2     = 16'sd4809,
  parameter logic signed [15:0] C3     = 16'sd934,
  parameter logic signed [31:0] OFFSET = 32'sd0,
  parameter int                 FRAC   = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       dvalid_in,
  input  logic [7:0] vdata_in,
  output logic       dvalid_out,
  output logic [7:0] vdata_out,
  output logic       proto_err
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 16;
  localparam int PROD_W = 25;
  localparam int ACC_W  = 28;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_B1   = 2'd1;
  localparam logic [1:0] S_B2   = 2'd2;

  // Offset plus half an LSB, so the final floor rounds half up.
  localparam logic signed [ACC_W-1:0] ACC_BASE =
    ACC_W'(OFFSET + (32'sd1 <<< (FRAC - 1)));

  function automatic logic [DATA_W-1:0] sat_u8(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (a < 0)
      return '0;
    else if (s > ACC_W'(255))
      return 8'd255;
    else
      return a[FRAC+DATA_W-1:FRAC];
  endfunction

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic                      w_abort;

  logic                      r_vld_p0;
  logic [1:0]                r_beat_p0;
  logic [DATA_W-1:0]         r_data_p0;

  logic signed [COEF_W-1:0]  w_coef;
  logic signed [PROD_W-1:0]  w_opnd;
  logic signed [PROD_W-1:0]  w_coef_x;
  logic signed [PROD_W-1:0]  w_prod;

  logic                      r_vld_p1;
  logic [1:0]                r_beat_p1;
  logic signed [PROD_W-1:0]  r_prod_p1;

  logic signed [ACC_W-1:0]   w_prod_x;
  logic signed [ACC_W-1:0]   r_acc_p2;
  logic                      r_done_p2;

  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = dvalid_in ? S_B1 : S_IDLE;
      S_B1: begin
        w_abort     = dvalid_in;
        w_state_nxt = dvalid_in ? S_B1 : S_B2;
      end
      S_B2: begin
        w_abort     = dvalid_in;
        w_state_nxt = dvalid_in ? S_B1 : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: beat sequencing and input capture. A start byte inside a triple
  // restarts as beat 0; the orphaned partial never reaches beat 2, so it never outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_vld_p0  <= 1'b0;
      r_beat_p0 <= 2'd0;
      r_data_p0 <= '0;
      proto_err <= 1'b0;
    end else if (clk_en) begin
      r_state   <= w_state_nxt;
      r_vld_p0  <= dvalid_in || (r_state != S_IDLE);
      r_beat_p0 <= dvalid_in ? 2'd0 : ((r_state == S_B1) ? 2'd1 : 2'd2);
      r_data_p0 <= vdata_in;
      proto_err <= w_abort;
    end
  end

  always_comb begin
    case (r_beat_p0)
      2'd0:    w_coef = C1;
      2'd1:    w_coef = C2;
      default: w_coef = C3;
    endcase
    w_opnd   = {{(PROD_W-DATA_W){1'b0}}, r_data_p0};
    w_coef_x = {{(PROD_W-COEF_W){w_coef[COEF_W-1]}}, w_coef};
    w_prod   = w_opnd * w_coef_x;
  end

  // Stage p1: registered product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_beat_p1 <= 2'd0;
      r_prod_p1 <= '0;
    end else if (clk_en) begin
      r_vld_p1  <= r_vld_p0;
      r_beat_p1 <= r_beat_p0;
      r_prod_p1 <= w_prod;
    end
  end

  assign w_prod_x = {{(ACC_W-PROD_W){r_prod_p1[PROD_W-1]}}, r_prod_p1};

  // Stage p2: accumulator; beat 0 reloads, so one accumulator serves back-to-back triples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_p2  <= '0;
      r_done_p2 <= 1'b0;
    end else if (clk_en) begin
      r_done_p2 <= r_vld_p1 && (r_beat_p1 == 2'd2);
      if (r_vld_p1) begin
        if (r_beat_p1 == 2'd0)
          r_acc_p2 <= ACC_BASE + w_prod_x;
        else
          r_acc_p2 <= r_acc_p2 + w_prod_x;
      end
    end
  end

  // Output stage: clamp and hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvalid_out <= 1'b0;
      vdata_out  <= '0;
    end else if (clk_en) begin
      dvalid_out <= r_done_p2;
      if (r_done_p2)
        vdata_out <= sat_u8(r_acc_p2);
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_mac.sv
// Directed bench for rgb2ycbcr_mac: Y, Cb and two saturation-test channels
// share one input stream; expected values are hand-computed constants.
module tb_rgb2ycbcr_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       dvalid_in;
  logic [7:0] vdata_in;

  logic       y_dv,  cb_dv,  sp_dv,  sn_dv;
  logic [7:0] y_d,   cb_d,   sp_d,   sn_d;
  logic       y_pe,  cb_pe,  sp_pe,  sn_pe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb2ycbcr_mac #(.C1(16'sd2449), .C2(16'sd4809), .C3(16'sd934), .OFFSET(32'sd0), .FRAC(13)) u_y (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dvalid_in(dvalid_in), .vdata_in(vdata_in),
    .dvalid_out(y_dv), .vdata_out(y_d), .proto_err(y_pe));

  rgb2ycbcr_mac #(.C1(-16'sd1382), .C2(-16'sd2714), .C3(16'sd4096), .OFFSET(32'sd1048576), .FRAC(13)) u_cb (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dvalid_in(dvalid_in), .vdata_in(vdata_in),
    .dvalid_out(cb_dv), .vdata_out(cb_d), .proto_err(cb_pe));

  rgb2ycbcr_mac #(.C1(16'sd16384), .C2(16'sd0), .C3(16'sd0), .OFFSET(32'sd0), .FRAC(13)) u_sp (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dvalid_in(dvalid_in), .vdata_in(vdata_in),
    .dvalid_out(sp_dv), .vdata_out(sp_d), .proto_err(sp_pe));

  rgb2ycbcr_mac #(.C1(-16'sd8192), .C2(16'sd0), .C3(16'sd0), .OFFSET(32'sd0), .FRAC(13)) u_sn (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dvalid_in(dvalid_in), .vdata_in(vdata_in),
    .dvalid_out(sn_dv), .vdata_out(sn_d), .proto_err(sn_pe));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    dvalid_in = v;
    vdata_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic triple(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    cyc(1'b1, r);
    cyc(1'b0, g);
    cyc(1'b0, b);
  endtask

  // Leaves the bench just after the n+5 edge, with the n+4 and n+5 pulses checked.
  task automatic xact(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    triple(r, g, b);
    cyc(1'b0, 8'd0);
    cyc(1'b0, 8'd0);
    chk("lat_early", y_dv, 0);
    cyc(1'b0, 8'd0);
    chk("lat_dv", y_dv, 1);
    chk("lat_cb_dv", cb_dv, 1);
  endtask

  logic [7:0] stim [12] = '{8'd10, 8'd20, 8'd30, 8'd255, 8'd0, 8'd0,
                            8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
  logic [7:0] exp_y [4] = '{8'd18, 8'd76, 8'd150, 8'd29};

  initial begin
    rst = 1'b0; clk_en = 1'b1; dvalid_in = 1'b0; vdata_in = 8'd0;
    #1;
    chk("rst_dv", y_dv, 0);
    chk("rst_d", y_d, 0);
    chk("rst_pe", y_pe, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // T1: white and black through Y; Cb of grey sits at 128
    xact(8'd255, 8'd255, 8'd255);
    chk("t1_y_white", y_d, 255);
    chk("t1_cb_white", cb_d, 128);
    chk("t1_sp_white", sp_d, 255);
    chk("t1_sn_white", sn_d, 0);
    cyc(1'b0, 8'd0);
    chk("t1_pulse_end", y_dv, 0);
    chk("t1_hold", y_d, 255);
    xact(8'd0, 8'd0, 8'd0);
    chk("t1_y_black", y_d, 0);
    chk("t1_cb_black", cb_d, 128);

    // T2: Cb of pure red and pure blue
    xact(8'd255, 8'd0, 8'd0);
    chk("t2_cb_red", cb_d, 85);
    chk("t2_y_red", y_d, 76);
    xact(8'd0, 8'd0, 8'd255);
    chk("t2_cb_blue", cb_d, 255);
    chk("t2_y_blue", y_d, 29);

    // T3: saturation, both directions, plus the 254/255 boundary
    xact(8'd200, 8'd0, 8'd0);
    chk("t3_sp_200", sp_d, 255);
    chk("t3_y_200", y_d, 60);
    xact(8'd10, 8'd0, 8'd0);
    chk("t3_sn_10", sn_d, 0);
    chk("t3_sp_10", sp_d, 20);
    chk("t3_y_10", y_d, 3);
    xact(8'd127, 8'd0, 8'd0);
    chk("t3_sp_127", sp_d, 254);
    xact(8'd128, 8'd0, 8'd0);
    chk("t3_sp_128", sp_d, 255);

    // T4: four back-to-back triples
    for (int c = 0; c < 16; c++) begin
      cyc((c < 12) && (c % 3 == 0), (c < 12) ? stim[c] : 8'd0);
      chk("t4_pe", y_pe, 0);
      if (c >= 5 && c <= 14 && ((c - 5) % 3 == 0)) begin
        chk("t4_dv", y_dv, 1);
        chk("t4_d", y_d, exp_y[(c - 5) / 3]);
      end else begin
        chk("t4_dv_idle", y_dv, 0);
      end
    end

    // T5a: restart in B1
    cyc(1'b1, 8'd255);
    chk("t5a_pe_lo", y_pe, 0);
    cyc(1'b1, 8'd10);
    chk("t5a_pe", y_pe, 1);
    cyc(1'b0, 8'd20);
    chk("t5a_pe_end", y_pe, 0);
    cyc(1'b0, 8'd30);
    cyc(1'b0, 8'd0);
    cyc(1'b0, 8'd0);
    chk("t5a_no_old", y_dv, 0);
    cyc(1'b0, 8'd0);
    chk("t5a_dv", y_dv, 1);
    chk("t5a_d", y_d, 18);

    // T5b: restart in B2
    cyc(1'b1, 8'd0);
    cyc(1'b0, 8'd255);
    cyc(1'b1, 8'd255);
    chk("t5b_pe", y_pe, 1);
    cyc(1'b0, 8'd0);
    chk("t5b_pe_end", y_pe, 0);
    cyc(1'b0, 8'd0);
    cyc(1'b0, 8'd0);
    chk("t5b_no_old5", y_dv, 0);
    cyc(1'b0, 8'd0);
    chk("t5b_no_old6", y_dv, 0);
    cyc(1'b0, 8'd0);
    chk("t5b_dv", y_dv, 1);
    chk("t5b_y", y_d, 76);
    chk("t5b_cb", cb_d, 85);
    cyc(1'b0, 8'd0);

    // T5c: 4-cycle stall after G, with garbage starts that must be ignored
    cyc(1'b1, 8'd10);
    cyc(1'b0, 8'd20);
    clk_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, 8'd99);
      chk("t5c_stall_dv", y_dv, 0);
      chk("t5c_stall_pe", y_pe, 0);
    end
    clk_en = 1'b1;
    cyc(1'b0, 8'd30);
    cyc(1'b0, 8'd0);
    cyc(1'b0, 8'd0);
    chk("t5c_early", y_dv, 0);
    cyc(1'b0, 8'd0);
    chk("t5c_dv", y_dv, 1);
    chk("t5c_d", y_d, 18);
    chk("t5c_pe", y_pe, 0);
    clk_en = 1'b0;
    cyc(1'b0, 8'd0);
    cyc(1'b0, 8'd0);
    chk("t5c_hold_dv", y_dv, 1);
    clk_en = 1'b1;
    cyc(1'b0, 8'd0);
    chk("t5c_dv_end", y_dv, 0);
    chk("t5c_hold_d", y_d, 18);

    // T6: asynchronous reset at n+3 of an in-flight triple
    triple(8'd255, 8'd255, 8'd255);
    dvalid_in = 1'b0;
    vdata_in  = 8'd0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_d", y_d, 0);
    chk("t6_rst_dv", y_dv, 0);
    chk("t6_rst_pe", y_pe, 0);
    chk("t6_rst_cb", cb_d, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 8'd0);
      chk("t6_no_dv", y_dv, 0);
    end
    xact(8'd255, 8'd0, 8'd0);
    chk("t6_after_y", y_d, 76);
    chk("t6_after_cb", cb_d, 85);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
